// File: rtl/equiv_stim_sequencer_if.sv
// Bundle of the sequencer's control, stimulus, DUT-response and result signals.
// The slave modport is the sequencer side and the master modport is the harness side.
interface equiv_stim_sequencer_if #(
    parameter int unsigned STIM_W = 68,
    parameter int unsigned Y_W    = 91,
    parameter int unsigned CNT_W  = 16
);
    logic                start;
    logic [CNT_W-1:0]    num_vec;
    logic [STIM_W-1:0]   seed;
    logic [3:0]          wire0;
    logic [15:0]         wire1;
    logic [19:0]         wire2;
    logic signed [20:0]  wire3;
    logic [6:0]          wire4;
    logic [Y_W-1:0]      y_1;
    logic [Y_W-1:0]      y_2;
    logic                busy;
    logic                done;
    logic                mismatch;
    logic [CNT_W-1:0]    mismatch_cnt;
    logic [CNT_W-1:0]    first_fail_idx;

    modport master (
        output start, num_vec, seed, y_1, y_2,
        input  wire0, wire1, wire2, wire3, wire4,
        input  busy, done, mismatch, mismatch_cnt, first_fail_idx
    );

    modport slave (
        input  start, num_vec, seed, y_1, y_2,
        output wire0, wire1, wire2, wire3, wire4,
        output busy, done, mismatch, mismatch_cnt, first_fail_idx
    );
endinterface

// File: rtl/equiv_stim_sequencer.sv
// LFSR stimulus sequencer and y_1/y_2 output comparator for the equivalence harness.
// Optional macro STOP_ON_FAIL_EN: end the run at the first failing vector.
module equiv_stim_sequencer #(
    parameter int unsigned STIM_W = 68,
    parameter int unsigned Y_W    = 91,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    equiv_stim_sequencer_if.slave bus
);
    localparam int unsigned SET_W = 8;
    localparam int unsigned TAP_A = 67;
    localparam int unsigned TAP_B = 58;

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                rst_ni;
    logic [STIM_W-1:0]   lfsr_q, lfsr_d;
    logic [STIM_W-1:0]   stim_q, stim_d;
    logic [CNT_W-1:0]    nvec_q, nvec_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    mcnt_q, mcnt_d;
    logic [CNT_W-1:0]    ffi_q, ffi_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic                mis_q, mis_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [Y_W-1:0]      y_diff_c;
    logic                fail_c;
    logic                last_c;
    logic [STIM_W-1:0]   lfsr_step_c;

    // Reset asserts asynchronously and releases two clocks later, in sync with clk.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end
    assign rst_ni = rst_sync_q[1];

    assign y_diff_c    = bus.y_1 ^ bus.y_2;
    assign fail_c      = |y_diff_c;
    assign last_c      = (idx_q == (nvec_q - CNT_W'(1)));
    assign lfsr_step_c = {lfsr_q[STIM_W-2:0], lfsr_q[TAP_A] ^ lfsr_q[TAP_B]};

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = (bus.num_vec == '0) ? S_DONE : S_APPLY;
            end
            S_APPLY:  state_d = (LAT == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE: begin
                if (set_q <= SET_W'(1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = last_c ? S_DONE : S_APPLY;
`ifdef STOP_ON_FAIL_EN
                if (fail_c) state_d = S_DONE;
`endif
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered status updates for the transition being taken.
    always_comb begin
        lfsr_d = lfsr_q;
        stim_d = stim_q;
        nvec_d = nvec_q;
        idx_d  = idx_q;
        mcnt_d = mcnt_q;
        ffi_d  = ffi_q;
        set_d  = set_q;
        mis_d  = mis_q;
        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.num_vec != '0)) begin
                    nvec_d = bus.num_vec;
                    lfsr_d = (bus.seed == '0) ? STIM_W'(1) : bus.seed;
                    idx_d  = '0;
                    mis_d  = 1'b0;
                    mcnt_d = '0;
                    ffi_d  = '0;
                end
            end
            S_APPLY: begin
                stim_d = lfsr_q;
                set_d  = SET_W'(LAT);
            end
            S_SETTLE: set_d = set_q - SET_W'(1);
            S_CHECK: begin
                if (fail_c) begin
                    mis_d = 1'b1;
                    if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
                    if (!mis_q) ffi_d = idx_q;
                end
`ifdef STOP_ON_FAIL_EN
                if (!fail_c) begin
                    lfsr_d = lfsr_step_c;
                    idx_d  = idx_q + CNT_W'(1);
                end
`else
                lfsr_d = lfsr_step_c;
                idx_d  = idx_q + CNT_W'(1);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= '0;
            stim_q <= '0;
            nvec_q <= '0;
            idx_q  <= '0;
            mcnt_q <= '0;
            ffi_q  <= '0;
            set_q  <= '0;
            mis_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            stim_q <= stim_d;
            nvec_q <= nvec_d;
            idx_q  <= idx_d;
            mcnt_q <= mcnt_d;
            ffi_q  <= ffi_d;
            set_q  <= set_d;
            mis_q  <= mis_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.wire0          = stim_q[3:0];
    assign bus.wire1          = stim_q[19:4];
    assign bus.wire2          = stim_q[39:20];
    assign bus.wire3          = $signed(stim_q[60:40]);
    assign bus.wire4          = stim_q[67:61];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mismatch       = mis_q;
    assign bus.mismatch_cnt   = mcnt_q;
    assign bus.first_fail_idx = ffi_q;
endmodule
